// File: rtl/johnson_decoder.sv
// Johnson-code receiver: checks each sampled code, converts it to a phase index, locks onto correctly
// counting streams and counts sequencing errors. Define JOHNSON_DIR_EN to also accept backward counting (adds a dir output).
module johnson_decoder #(
  parameter int WIDTH    = 4,
  parameter int IDX_W    = 3,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] code_in,
  output logic             valid_out,
  output logic [IDX_W-1:0] index_out,
  output logic             legal_out,
  output logic             locked,
  output logic             seq_err,
  output logic [7:0]       err_count
`ifdef JOHNSON_DIR_EN
  ,
  output logic             dir
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * WIDTH - 1);
  localparam logic [3:0]       LOCK_V   = 4'(LOCK_CNT);

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_sc, w_sc_nxt, w_sc_step;
  logic [7:0]       r_err, w_err_nxt;
  logic             r_seq_err, w_seq_nxt;
  logic             r_valid, r_legal, r_p_valid;
  logic [IDX_W-1:0] r_index;
  logic             w_legal;
  logic [IDX_W-1:0] w_idx, w_idx_adv;
  logic             w_good, w_fwd, w_hold, w_bwd, w_bad, w_dir_chg;

  function automatic logic [WIDTH-1:0] low_ones(input int k);
    return (WIDTH'(1) << k) - WIDTH'(1);
  endfunction

  // Lower half of the ring is 2^k-1 (index k); upper half is its complement (index N+k).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_legal = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (code_in == low_ones(k)) begin
        w_legal = 1'b1;
        w_idx   = IDX_W'(k);
      end
      if (code_in == ~low_ones(k)) begin
        w_legal = 1'b1;
        w_idx   = IDX_W'(WIDTH + k);
      end
    end
  end

  assign w_idx_adv = (r_index == LAST_IDX) ? '0 : r_index + IDX_W'(1);
  assign w_good    = valid_in && w_legal && r_p_valid;
  assign w_fwd     = w_good && (w_idx == w_idx_adv);
  assign w_hold    = w_good && (w_idx == r_index);

`ifdef JOHNSON_DIR_EN
  logic             r_dir;
  logic [IDX_W-1:0] w_idx_ret;
  assign w_idx_ret = (r_index == '0) ? LAST_IDX : r_index - IDX_W'(1);
  assign w_bwd     = w_good && (w_idx == w_idx_ret);
  assign w_dir_chg = (w_fwd && r_dir) || (w_bwd && !r_dir);
  assign dir       = r_dir;
`else
  assign w_bwd     = 1'b0;
  assign w_dir_chg = 1'b0;
`endif

  // A legal sample with no valid previous index only reloads p and is never classed.
  assign w_bad     = valid_in && (!w_legal || (r_p_valid && !(w_fwd || w_hold || w_bwd)));
  assign w_sc_step = w_dir_chg ? 4'd1 : r_sc + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_err_nxt   = r_err;
    w_seq_nxt   = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_bad) begin
          w_sc_nxt = '0;
        end else if (w_fwd || w_bwd) begin
          if (w_sc_step >= LOCK_V) begin
            w_state_nxt = ST_LOCKED;
            w_sc_nxt    = '0;
          end else begin
            w_sc_nxt = w_sc_step;
          end
        end
      end
      ST_LOCKED: begin
        if (w_bad) begin
          w_seq_nxt   = 1'b1;
          w_err_nxt   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
          w_state_nxt = ST_UNLOCKED;
          w_sc_nxt    = '0;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_UNLOCKED;
      r_sc      <= '0;
      r_err     <= '0;
      r_seq_err <= 1'b0;
      r_valid   <= 1'b0;
      r_legal   <= 1'b0;
      r_p_valid <= 1'b0;
      r_index   <= '0;
`ifdef JOHNSON_DIR_EN
      r_dir     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_sc      <= w_sc_nxt;
      r_err     <= w_err_nxt;
      r_seq_err <= w_seq_nxt;
      r_valid   <= valid_in;
      if (valid_in) begin
        r_legal   <= w_legal;
        r_p_valid <= w_legal;
        if (w_legal) r_index <= w_idx;
      end
`ifdef JOHNSON_DIR_EN
      if (w_fwd)      r_dir <= 1'b0;
      else if (w_bwd) r_dir <= 1'b1;
`endif
    end
  end

  assign valid_out = r_valid;
  assign index_out = r_index;
  assign legal_out = r_legal;
  assign locked    = (r_state == ST_LOCKED);
  assign seq_err   = r_seq_err;
  assign err_count = r_err;

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: a hand-computed vector table, random traffic
// against a sequence-table reference model, error-count saturation and asynchronous reset.
module tb_johnson_decoder;

  localparam int LOCK_CNT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_in = 1'b0;
  logic [3:0] code_in = 4'h0;
  logic       valid_out, legal_out, locked, seq_err;
  logic [2:0] index_out;
  logic [7:0] err_count;
`ifdef JOHNSON_DIR_EN
  logic       dir;
`endif

  always #5 clk = ~clk;

  johnson_decoder #(.WIDTH(4), .IDX_W(3), .LOCK_CNT(LOCK_CNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .code_in   (code_in),
    .valid_out (valid_out),
    .index_out (index_out),
    .legal_out (legal_out),
    .locked    (locked),
    .seq_err   (seq_err),
    .err_count (err_count)
`ifdef JOHNSON_DIR_EN
    ,
    .dir       (dir)
`endif
  );

  typedef struct {
    logic       v;
    logic [3:0] code;
    logic [2:0] idx;
    logic       legal;
    logic       lk;
    logic       se;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   seq_tab[8] = '{0, 1, 3, 7, 15, 14, 12, 8};

  // Reference model state
  int m_idx, m_sc, m_err;
  bit m_vout, m_legal, m_locked, m_seq, m_pv, m_dir;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [3:0] c, input logic [2:0] i,
                              input logic l, input logic k, input logic s, input logic [7:0] e);
    vec_t r;
    r.v = v; r.code = c; r.idx = i; r.legal = l; r.lk = k; r.se = s; r.err = e;
    return r;
  endfunction

  function automatic int decode(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (seq_tab[i] == int'(c)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_sc = 0; m_err = 0;
    m_vout = 0; m_legal = 0; m_locked = 0; m_seq = 0; m_pv = 0; m_dir = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    int d;
    bit fwd, bwd, hold, bad, chg;
    m_vout = v;
    m_seq  = 0;
    if (!v) return;
    d = decode(c);
    m_legal = (d >= 0);
    fwd = 0; bwd = 0; hold = 0; bad = 0;
    if (d < 0) begin
      bad = 1; m_pv = 0;
    end else if (!m_pv) begin
      m_pv = 1; m_idx = d;
    end else begin
      fwd  = (d == (m_idx + 1) % 8);
      hold = (d == m_idx);
`ifdef JOHNSON_DIR_EN
      bwd  = (d == (m_idx + 7) % 8);
`endif
      bad  = !(fwd || hold || bwd);
      m_idx = d;
    end
    if (bad) begin
      if (m_locked) begin
        m_seq = 1;
        if (m_err < 255) m_err++;
        m_locked = 0;
      end
      m_sc = 0;
    end else if (fwd || bwd) begin
      chg = (fwd && m_dir) || (bwd && !m_dir);
      if (!m_locked) begin
        m_sc = chg ? 1 : m_sc + 1;
        if (m_sc >= LOCK_CNT) begin
          m_locked = 1; m_sc = 0;
        end
      end
      m_dir = bwd;
    end
  endtask

  task automatic apply(input logic v, input logic [3:0] c);
    valid_in = v;
    code_in  = c;
    @(posedge clk);
    #1;
    model_step(v, c);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid_out"}, valid_out, m_vout);
    check({tag, ".index_out"}, index_out, m_idx);
    check({tag, ".legal_out"}, legal_out, m_legal);
    check({tag, ".locked"},    locked,    m_locked);
    check({tag, ".seq_err"},   seq_err,   m_seq);
    check({tag, ".err_count"}, err_count, m_err);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid_out"}, valid_out, 0);
    check({tag, ".index_out"}, index_out, 0);
    check({tag, ".legal_out"}, legal_out, 0);
    check({tag, ".locked"},    locked,    0);
    check({tag, ".seq_err"},   seq_err,   0);
    check({tag, ".err_count"}, err_count, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_in = 1'b0;
    reset    = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int r, q;
    model_reset();

    // Full count, illegal code, skip, hold and idle gap, hand-derived expectations.
    tbl.push_back(mk(1, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'h3, 2, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h7, 3, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'hF, 4, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'hE, 5, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'hC, 6, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h8, 7, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'h5, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'hC, 6, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'h8, 7, 1, 0, 0, 1));
    tbl.push_back(mk(1, 4'h0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'h1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'h3, 2, 1, 1, 0, 1));
    tbl.push_back(mk(1, 4'hF, 4, 1, 0, 1, 2));
    tbl.push_back(mk(1, 4'hE, 5, 1, 0, 0, 2));
    tbl.push_back(mk(1, 4'hC, 6, 1, 1, 0, 2));
    tbl.push_back(mk(1, 4'h8, 7, 1, 1, 0, 2));
    tbl.push_back(mk(1, 4'h0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(1, 4'h1, 1, 1, 1, 0, 2));
    tbl.push_back(mk(1, 4'h3, 2, 1, 1, 0, 2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 4'h7, 3, 1, 1, 0, 2));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'h5, 3, 1, 1, 0, 2));
    tbl.push_back(mk(1, 4'hF, 4, 1, 1, 0, 2));

    #12;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].v, tbl[i].code);
      check($sformatf("t%0d.valid_out", i), valid_out, tbl[i].v);
      check($sformatf("t%0d.index_out", i), index_out, tbl[i].idx);
      check($sformatf("t%0d.legal_out", i), legal_out, tbl[i].legal);
      check($sformatf("t%0d.locked", i),    locked,    tbl[i].lk);
      check($sformatf("t%0d.seq_err", i),   seq_err,   tbl[i].se);
      check($sformatf("t%0d.err_count", i), err_count, tbl[i].err);
    end

    // Count up to index 0, then run backwards 8, C, E.
    apply(1, 4'hE); apply(1, 4'hC); apply(1, 4'h8); apply(1, 4'h0);
    check("up.locked", locked, 1);
    apply(1, 4'h8);
`ifdef JOHNSON_DIR_EN
    check("down1.seq_err", seq_err, 0);
    check("down1.dir", dir, 1);
`else
    check("down1.seq_err", seq_err, 1);
    check("down1.err_count", err_count, 3);
`endif
    apply(1, 4'hC);
    apply(1, 4'hE);
    check("down3.seq_err", seq_err, 0);
    check("down3.index_out", index_out, 5);
`ifdef JOHNSON_DIR_EN
    check("down3.locked", locked, 1);
    check("down3.dir", dir, 1);
`else
    check("down3.locked", locked, 0);
`endif

    // Random traffic, mostly well-formed counting with holds, gaps and corruption.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      if (r == 0)      apply(0, 4'($urandom_range(0, 15)));
      else if (r == 1) apply(1, 4'($urandom_range(0, 15)));
      else if (r == 2) apply(1, 4'(seq_tab[m_idx]));
      else if (r == 3) apply(1, 4'(seq_tab[(m_idx + 7) % 8]));
      else if (r == 4) apply(1, 4'(seq_tab[(m_idx + 3) % 8]));
      else             apply(1, 4'(seq_tab[(m_idx + 1) % 8]));
      check_model($sformatf("rnd%0d", i));
    end

    // Error counter saturation: skip one phase, then relock with two advances.
    do_reset();
    apply(1, 4'h0); apply(1, 4'h1); apply(1, 4'h3);
    check("sat_pre.locked", locked, 1);
    for (int i = 0; i < 300; i++) begin
      q = m_idx;
      apply(1, 4'(seq_tab[(q + 2) % 8]));
      if (i == 149) check("sat_mid.err_count", err_count, 150);
      apply(1, 4'(seq_tab[(q + 3) % 8]));
      apply(1, 4'(seq_tab[(q + 4) % 8]));
    end
    check("sat.err_count", err_count, 255);
    check("sat.locked", locked, 1);
    check_model("sat");

    // Reset asserted between clock edges clears outputs immediately.
    #3;
    reset = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    apply(1, 4'hC);
    check_model("post_rst0");
    apply(1, 4'h8);
    check_model("post_rst1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
